// File: rtl/shift_pipe.sv
// shift_pipe: pipelined ARM-style barrel shifter (LSL/LSR/ASR/ROR/RRX/bypass)
// with valid/ready stream handshake, 1 or 2 stages, tag sideband and flush.
// Ports:
//  i_clk, i_rst_n        clock, async active-low reset
//  i_flush               drop in-flight ops and this cycle's input
//  i_valid/o_ready       input handshake: i_op, i_type, i_amount,
//                        i_carry, i_tag
//  o_valid/i_ready       output handshake: o_result, o_carry, o_tag
module shift_pipe #(
  parameter int WIDTH  = 32,
  parameter int AMT_W  = 8,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_op,
  input  logic [2:0]       i_type,
  input  logic [AMT_W-1:0] i_amount,
  input  logic             i_carry,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic [TAG_W-1:0] o_tag
);

  localparam int LW = $clog2(WIDTH);
  localparam int LO = LW / 2;
  localparam int XW = 2 * WIDTH + 1;
  localparam logic [AMT_W-1:0] WA = AMT_W'(WIDTH);
  localparam logic [LW:0] WR = (LW + 1)'(WIDTH);

  function automatic logic [WIDTH-1:0] f_rev(
    input logic [WIDTH-1:0] v
  );
    logic [WIDTH-1:0] o;
    for (int i = 0; i < WIDTH; i++) begin
      o[i] = v[WIDTH-1-i];
    end
    return o;
  endfunction

  // Every op becomes one right shift of x = {fill, a, cin} by
  // w_r in 0..WIDTH: x[WIDTH:1] is the result, x[0] the carry-out.
  // LSL runs as LSR on the bit-reversed operand.
  logic             w_z;
  logic             w_lsl;
  logic             w_lsr;
  logic             w_asr;
  logic             w_ror;
  logic             w_rrx;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_a;
  logic             w_cin;
  logic             w_rev;
  logic [LW:0]      w_r;
  logic [XW-1:0]    w_xa;
  logic [LO-1:0]    w_rlo;

  assign w_z   = (i_amount == '0);
  assign w_lsl = (i_type == 3'd0) && !w_z;
  assign w_lsr = (i_type == 3'd1) && !w_z;
  assign w_asr = (i_type == 3'd2) && !w_z;
  assign w_ror = (i_type == 3'd3) && !w_z;
  assign w_rrx = (i_type == 3'd4);

  always_comb begin
    w_hi  = '0;
    w_a   = i_op;
    w_cin = i_carry;
    w_rev = 1'b0;
    w_r   = '0;
    unique case (1'b1)
      w_lsl: begin
        if (i_amount > WA) begin
          w_a   = '0;
          w_cin = 1'b0;
        end else begin
          w_a   = f_rev(i_op);
          w_rev = 1'b1;
          w_r   = i_amount[LW:0];
        end
      end
      w_lsr: begin
        if (i_amount > WA) begin
          w_a   = '0;
          w_cin = 1'b0;
        end else begin
          w_r = i_amount[LW:0];
        end
      end
      w_asr: begin
        w_hi = {WIDTH{i_op[WIDTH-1]}};
        if (i_amount >= WA) begin
          w_r = WR;
        end else begin
          w_r = i_amount[LW:0];
        end
      end
      w_ror: begin
        w_hi = i_op;
        w_r  = {1'b0, i_amount[LW-1:0]};
        // multiple of WIDTH: operand unchanged, carry = msb
        if (i_amount[LW-1:0] == '0) begin
          w_cin = i_op[WIDTH-1];
        end
      end
      w_rrx: begin
        w_hi = {{(WIDTH-1){1'b0}}, i_carry};
        w_r  = {{LW{1'b0}}, 1'b1};
      end
      default: begin
      end
    endcase
  end

  // coarse part of the shift; the low LO bits finish later
  assign w_xa  = {w_hi, w_a, w_cin} >> {w_r[LW:LO], {LO{1'b0}}};
  assign w_rlo = w_r[LO-1:0];

  logic [XW-1:0]    w_fx;
  logic [LO-1:0]    w_frlo;
  logic             w_frev;
  logic [TAG_W-1:0] w_ftag;
  logic [WIDTH:0]   w_y;
  logic [WIDTH-1:0] w_fres;
  logic             w_ld;

  assign w_y    = (WIDTH + 1)'(w_fx >> w_frlo);
  assign w_fres = w_frev ? f_rev(w_y[WIDTH:1]) : w_y[WIDTH:1];

  logic             r_vo;
  logic [WIDTH-1:0] r_res;
  logic             r_car;
  logic [TAG_W-1:0] r_tag;

  if (STAGES == 2) begin : g_two
    logic             r_v0;
    logic [XW-1:0]    r_x0;
    logic [LO-1:0]    r_rlo0;
    logic             r_rev0;
    logic [TAG_W-1:0] r_tag0;
    logic             w_adv0;

    assign w_adv0  = r_v0 && (!r_vo || i_ready);
    assign o_ready = !r_v0 || w_adv0;
    assign w_ld    = w_adv0;
    assign w_fx    = r_x0;
    assign w_frlo  = r_rlo0;
    assign w_frev  = r_rev0;
    assign w_ftag  = r_tag0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_v0   <= 1'b0;
        r_x0   <= '0;
        r_rlo0 <= '0;
        r_rev0 <= 1'b0;
        r_tag0 <= '0;
      end else if (i_flush) begin
        r_v0 <= 1'b0;
      end else if (o_ready) begin
        r_v0 <= i_valid;
        if (i_valid) begin
          r_x0   <= w_xa;
          r_rlo0 <= w_rlo;
          r_rev0 <= w_rev;
          r_tag0 <= i_tag;
        end
      end
    end
  end else begin : g_one
    assign o_ready = !r_vo || i_ready;
    assign w_ld    = i_valid && o_ready;
    assign w_fx    = w_xa;
    assign w_frlo  = w_rlo;
    assign w_frev  = w_rev;
    assign w_ftag  = i_tag;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vo  <= 1'b0;
      r_res <= '0;
      r_car <= 1'b0;
      r_tag <= '0;
    end else if (i_flush) begin
      r_vo <= 1'b0;
    end else if (w_ld) begin
      r_vo  <= 1'b1;
      r_res <= w_fres;
      r_car <= w_y[0];
      r_tag <= w_ftag;
    end else if (i_ready) begin
      r_vo <= 1'b0;
    end
  end

  assign o_valid  = r_vo;
  assign o_result = r_res;
  assign o_carry  = r_car;
  assign o_tag    = r_tag;

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed bench for shift_pipe, W=32/S=2 and W=64/S=1,
// reference model + per-instance expected-result queues.
module tb_shift_pipe;

  typedef struct packed {
    logic [63:0] res;
    logic        c;
    logic [3:0]  tag;
  } exp_t;

  logic clk;
  logic rst_n;
  logic flush;

  logic        a_valid, a_ordy, a_rdy, a_ovalid, a_cin, a_car;
  logic [31:0] a_op, a_res;
  logic [2:0]  a_type;
  logic [7:0]  a_amt;
  logic [3:0]  a_tagi, a_tago;

  logic        b_valid, b_ordy, b_rdy, b_ovalid, b_cin, b_car;
  logic [63:0] b_op, b_res;
  logic [2:0]  b_type;
  logic [7:0]  b_amt;
  logic [3:0]  b_tagi, b_tago;

  exp_t qa[$];
  exp_t qb[$];
  int   n_vec;
  int   n_err;

  shift_pipe #(
    .WIDTH(32), .AMT_W(8), .STAGES(2), .TAG_W(4)
  ) ua (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_valid(a_valid), .o_ready(a_ordy), .i_op(a_op),
    .i_type(a_type), .i_amount(a_amt), .i_carry(a_cin),
    .i_tag(a_tagi), .o_valid(a_ovalid), .i_ready(a_rdy),
    .o_result(a_res), .o_carry(a_car), .o_tag(a_tago)
  );

  shift_pipe #(
    .WIDTH(64), .AMT_W(8), .STAGES(1), .TAG_W(4)
  ) ub (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_valid(b_valid), .o_ready(b_ordy), .i_op(b_op),
    .i_type(b_type), .i_amount(b_amt), .i_carry(b_cin),
    .i_tag(b_tagi), .o_valid(b_ovalid), .i_ready(b_rdy),
    .o_result(b_res), .o_carry(b_car), .o_tag(b_tago)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [64:0] obs,
                     input logic [64:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] ref_shift(
    input int w, input logic [63:0] op, input logic [2:0] t,
    input int n, input logic c);
    logic [63:0] m, r;
    logic k;
    int q;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    r = op;
    k = c;
    if (t == 3'd4) begin
      r = (op >> 1) | ({63'd0, c} << (w - 1));
      k = op[0];
    end else if (t > 3'd4 || n == 0) begin
      r = op;
    end else if (t == 3'd0) begin
      if (n < w) begin r = (op << n) & m; k = op[w-n]; end
      else if (n == w) begin r = '0; k = op[0]; end
      else begin r = '0; k = 1'b0; end
    end else if (t == 3'd1) begin
      if (n < w) begin r = op >> n; k = op[n-1]; end
      else if (n == w) begin r = '0; k = op[w-1]; end
      else begin r = '0; k = 1'b0; end
    end else if (t == 3'd2) begin
      if (n < w) begin
        r = (op >> n) | (op[w-1] ? (m & ~(m >> n)) : '0);
        k = op[n-1];
      end else begin
        r = op[w-1] ? m : '0;
        k = op[w-1];
      end
    end else begin
      q = n % w;
      if (q != 0) begin
        r = ((op >> q) | (op << (w - q))) & m;
        k = op[q-1];
      end else begin
        r = op;
        k = op[w-1];
      end
    end
    return {k, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [31:0] op, input logic [2:0] t,
                        input int n, input logic c,
                        input logic [3:0] tag);
    logic [64:0] e;
    logic acc;
    acc = 1'b0;
    a_valid = 1'b1; a_op = op; a_type = t;
    a_amt = 8'(n); a_cin = c; a_tagi = tag;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_ordy) begin acc = 1'b1; break; end
    end
    chk("accept_a", 65'(acc), 65'd1);
    if (acc) begin
      e = ref_shift(32, {32'd0, op}, t, n, c);
      qa.push_back('{res: e[63:0], c: e[64], tag: tag});
    end
    step();
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [63:0] op, input logic [2:0] t,
                        input int n, input logic c,
                        input logic [3:0] tag);
    logic [64:0] e;
    logic acc;
    acc = 1'b0;
    b_valid = 1'b1; b_op = op; b_type = t;
    b_amt = 8'(n); b_cin = c; b_tagi = tag;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b_ordy) begin acc = 1'b1; break; end
    end
    chk("accept_b", 65'(acc), 65'd1);
    if (acc) begin
      e = ref_shift(64, op, t, n, c);
      qb.push_back('{res: e[63:0], c: e[64], tag: tag});
    end
    step();
    b_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      step();
    end
    chk("drain_a", 65'(qa.size()), 65'd0);
    chk("drain_b", 65'(qb.size()), 65'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && !flush && a_ovalid && a_rdy) begin
      chk("a_pending", 65'(qa.size() != 0), 65'd1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("a_res", 65'(a_res), 65'(e.res[31:0]));
        chk("a_car", 65'(a_car), 65'(e.c));
        chk("a_tag", 65'(a_tago), 65'(e.tag));
      end
    end
    if (rst_n && !flush && b_ovalid && b_rdy) begin
      chk("b_pending", 65'(qb.size() != 0), 65'd1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_res", 65'(b_res), 65'(e.res));
        chk("b_car", 65'(b_car), 65'(e.c));
        chk("b_tag", 65'(b_tago), 65'(e.tag));
      end
    end
  end

  initial begin
    logic [31:0] s_res;
    logic        s_car;
    logic [3:0]  s_tag;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0; flush = 1'b0;
    a_valid = 0; a_op = '0; a_type = '0; a_amt = '0;
    a_cin = 0; a_tagi = '0; a_rdy = 1'b1;
    b_valid = 0; b_op = '0; b_type = '0; b_amt = '0;
    b_cin = 0; b_tagi = '0; b_rdy = 1'b1;
    #12;
    chk("rst_a_valid", 65'(a_ovalid), 65'd0);
    chk("rst_a_res", 65'(a_res), 65'd0);
    chk("rst_a_car", 65'(a_car), 65'd0);
    chk("rst_a_tag", 65'(a_tago), 65'd0);
    chk("rst_a_ready", 65'(a_ordy), 65'd1);
    chk("rst_b_valid", 65'(b_ovalid), 65'd0);
    chk("rst_b_res", 65'(b_res), 65'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // latency: S=2 valid one edge after the accept edge
    send_a(32'h8000_0001, 3'd0, 1, 1'b0, 4'd1);
    chk("lat_a_early", 65'(a_ovalid), 65'd0);
    step();
    chk("lat_a_valid", 65'(a_ovalid), 65'd1);
    chk("lat_a_res", 65'(a_res), 65'h2);
    chk("lat_a_car", 65'(a_car), 65'd1);
    drain();

    // boundary table, back to back
    send_a(32'h8000_0000, 3'd1, 32, 1'b0, 4'd2);
    send_a(32'h8000_0000, 3'd1, 33, 1'b1, 4'd3);
    send_a(32'h0000_0001, 3'd0, 32, 1'b0, 4'd4);
    send_a(32'h0000_0001, 3'd0, 64, 1'b1, 4'd5);
    send_a(32'h8000_0000, 3'd2, 200, 1'b0, 4'd6);
    send_a(32'h8000_0000, 3'd2, 4, 1'b1, 4'd7);
    send_a(32'h0000_00F1, 3'd3, 36, 1'b1, 4'd8);
    send_a(32'h8000_0000, 3'd3, 32, 1'b0, 4'd9);
    send_a(32'h0000_0003, 3'd4, 7, 1'b1, 4'd10);
    send_a(32'h1234_5678, 3'd6, 5, 1'b1, 4'd11);
    send_a(32'hDEAD_BEEF, 3'd0, 0, 1'b1, 4'd12);
    send_a(32'hF000_000F, 3'd1, 255, 1'b1, 4'd13);
    drain();

    // backpressure: i_ready low for three edges
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          send_a($urandom, 3'($urandom_range(0, 7)),
                 int'($urandom_range(0, 70)), 1'($urandom),
                 4'(i));
        end
      end
      begin
        a_rdy = 1'b0;
        step();
        step();
        chk("bp_ready_low", 65'(a_ordy), 65'd0);
        chk("bp_valid", 65'(a_ovalid), 65'd1);
        s_res = a_res; s_car = a_car; s_tag = a_tago;
        step();
        chk("bp_hold_res", 65'(a_res), 65'(s_res));
        chk("bp_hold_car", 65'(a_car), 65'(s_car));
        chk("bp_hold_tag", 65'(a_tago), 65'(s_tag));
        chk("bp_tag1", 65'(a_tago), 65'd1);
        a_rdy = 1'b1;
      end
    join
    drain();

    // flush with both stages full plus a same-cycle input
    a_rdy = 1'b0;
    send_a(32'h0000_00FF, 3'd0, 4, 1'b0, 4'd1);
    send_a(32'h0000_0F00, 3'd1, 4, 1'b0, 4'd2);
    a_valid = 1'b1; a_op = 32'h55; a_tagi = 4'd3;
    flush = 1'b1;
    step();
    flush = 1'b0; a_valid = 1'b0;
    qa.delete();
    chk("fl_valid", 65'(a_ovalid), 65'd0);
    a_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_quiet", 65'(a_ovalid), 65'd0);
    end
    // flush on an empty pipe while an input is accepted
    a_valid = 1'b1; a_op = 32'h77; a_type = 3'd3;
    a_amt = 8'd1; flush = 1'b1;
    step();
    flush = 1'b0; a_valid = 1'b0;
    step();
    step();
    chk("fl_drop_in", 65'(a_ovalid), 65'd0);

    // reset pulsed mid-stream
    a_rdy = 1'b0;
    send_a(32'hFFFF_FFFF, 3'd1, 1, 1'b0, 4'd14);
    send_a(32'h8000_0001, 3'd2, 1, 1'b0, 4'd15);
    rst_n = 1'b0;
    #1;
    qa.delete();
    chk("mrst_valid", 65'(a_ovalid), 65'd0);
    chk("mrst_res", 65'(a_res), 65'd0);
    chk("mrst_car", 65'(a_car), 65'd0);
    chk("mrst_tag", 65'(a_tago), 65'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_rdy = 1'b1;
    step();
    chk("mrst_ready", 65'(a_ordy), 65'd1);
    chk("mrst_quiet", 65'(a_ovalid), 65'd0);

    // W=64, S=1: one edge of latency
    send_b(64'h1, 3'd0, 63, 1'b1, 4'd1);
    chk("lat_b_valid", 65'(b_ovalid), 65'd1);
    chk("lat_b_res", 65'(b_res), 65'h8000_0000_0000_0000);
    chk("lat_b_car", 65'(b_car), 65'd0);
    send_b(64'h8000_0000_0000_0001, 3'd0, 64, 1'b0, 4'd2);
    send_b(64'h8000_0000_0000_0000, 3'd1, 65, 1'b1, 4'd3);
    send_b(64'h8000_0000_0000_0000, 3'd2, 64, 1'b0, 4'd4);
    send_b(64'h0123_4567_89AB_CDEF, 3'd3, 68, 1'b0, 4'd5);
    send_b(64'h0000_0000_0000_0002, 3'd4, 0, 1'b1, 4'd6);
    send_b(64'hC000_0000_0000_0000, 3'd3, 128, 1'b0, 4'd7);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", n_vec);
    $fatal(1, "timeout");
  end

endmodule
